// File: rtl/vec_pkg.sv
// Shared vector-unit definitions: lane geometry, write-back FSM states and vector funct codes.
package vec_pkg;

  localparam int unsigned VEC_LANES = 8;
  localparam int unsigned VEC_DW    = 32;

  // Write-back serializer states.
  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } wb_state_e;

  // Vector ALU function codes shared by the EX stages.
  typedef enum logic [2:0] {
    FnAddV = 3'd0,
    FnSubV = 3'd1,
    FnAndV = 3'd2,
    FnOrV  = 3'd3,
    FnXorV = 3'd4,
    FnMulV = 3'd5
  } vec_funct_e;

endpackage

// File: rtl/vec_lane_pe.sv
// Lowest-set-bit priority encoder over the lane mask.
module vec_lane_pe #(
  parameter int unsigned LANES = 8,
  parameter int unsigned IW    = $clog2(LANES)
) (
  input  logic [LANES-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_wb_serializer.sv
// Captures one vector result and writes its unmasked lanes one by one through a single
// memory write port. Optional per-vector byte stride when VEC_WB_STRIDE_EN is defined;
// otherwise lanes are written to contiguous words.
module vec_wb_serializer
  import vec_pkg::*;
#(
  parameter int unsigned LANES = VEC_LANES,
  parameter int unsigned DW    = VEC_DW,
  parameter int unsigned AW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       in_base_addr,
  input  logic [LANES*DW-1:0] in_data,
  input  logic [LANES-1:0]    in_mask,
`ifdef VEC_WB_STRIDE_EN
  input  logic [AW-1:0]       in_stride,
`endif
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned IW = $clog2(LANES);

  wb_state_e           state_q;
  logic [LANES*DW-1:0] data_q;
  logic [AW-1:0]       base_q;
  // Lanes still to write after the one currently on the port.
  logic [LANES-1:0]    pend_q;
`ifdef VEC_WB_STRIDE_EN
  logic [AW-1:0]       stride_q;
  logic [AW-1:0]       src_stride;
`endif

  logic                idle;
  logic [LANES-1:0]    pe_in;
  logic [IW-1:0]       pe_idx;
  logic                pe_any;
  logic [LANES*DW-1:0] src_data;
  logic [AW-1:0]       src_base;
  logic [AW-1:0]       lane_off;
  logic [AW-1:0]       nxt_addr;
  logic [DW-1:0]       nxt_wdata;
  logic [LANES-1:0]    lane_bit;
  logic [LANES-1:0]    pend_nxt;

  vec_lane_pe #(
    .LANES (LANES),
    .IW    (IW)
  ) u_pe (
    .req (pe_in),
    .idx (pe_idx),
    .any (pe_any)
  );

  // Select the next lane: from the incoming vector while idle, else from the captured one.
  always_comb begin
    idle     = (state_q == StIdle);
    pe_in    = idle ? in_mask : pend_q;
    src_data = idle ? in_data : data_q;
    src_base = idle ? in_base_addr : base_q;
`ifdef VEC_WB_STRIDE_EN
    src_stride = idle ? in_stride : stride_q;
    lane_off   = AW'(pe_idx) * src_stride;
`else
    lane_off   = AW'(pe_idx) << 2;
`endif
    nxt_addr  = src_base + lane_off;
    nxt_wdata = src_data[32'(pe_idx) * DW +: DW];
    lane_bit  = LANES'(1) << pe_idx;
    pend_nxt  = pe_in & ~lane_bit;
  end

  // FSM with registered memory-port and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      base_q    <= '0;
      pend_q    <= '0;
`ifdef VEC_WB_STRIDE_EN
      stride_q  <= '0;
`endif
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            base_q   <= in_base_addr;
`ifdef VEC_WB_STRIDE_EN
            stride_q <= in_stride;
`endif
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (pe_any) begin
              state_q   <= StWrite;
              mem_we    <= 1'b1;
              mem_addr  <= nxt_addr;
              mem_wdata <= nxt_wdata;
              pend_q    <= pend_nxt;
            end else begin
              // Empty mask: skip memory traffic entirely.
              state_q <= StDone;
              pend_q  <= '0;
              done    <= 1'b1;
            end
          end
        end
        StWrite: begin
          // Without mem_ready everything holds.
          if (mem_ready) begin
            if (pe_any) begin
              mem_addr  <= nxt_addr;
              mem_wdata <= nxt_wdata;
              pend_q    <= pend_nxt;
            end else begin
              state_q <= StDone;
              mem_we  <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          mem_we   <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_wb_serializer.sv
// Self-checking bench for vec_wb_serializer: table of vectors with a write scoreboard,
// plus hand-written reset-mid-vector sequence. Honours VEC_WB_STRIDE_EN.
module tb_vec_wb_serializer;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [AW-1:0]       in_base_addr;
  logic [LANES*DW-1:0] in_data;
  logic [LANES-1:0]    in_mask;
  logic [AW-1:0]       in_stride;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_ready;
  logic                busy;
  logic                done;

  vec_wb_serializer #(
    .LANES (LANES),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_base_addr (in_base_addr),
    .in_data      (in_data),
    .in_mask      (in_mask),
`ifdef VEC_WB_STRIDE_EN
    .in_stride    (in_stride),
`endif
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    base;
    logic [LANES-1:0] mask;
    logic [AW-1:0]    stride;
    int               stall_at;  // accepted-write index to stall on, -1 for none
    int               stall_n;
    int               exp_done;  // cycles after capture edge
    bit               rnd;       // random lane data instead of 0x11*i
    bit               noise;     // drive a different vector while busy
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t tbl[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [AW-1:0] stride;
    logic [DW-1:0] lane;
    wr_t           w;
    int            k;
    int            acc;
    int            stall_left;
    bit            seen_done;
    stride = 32'd4;
`ifdef VEC_WB_STRIDE_EN
    stride = v.stride;
`endif
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    for (int i = 0; i < int'(LANES); i++) begin
      lane = v.rnd ? $urandom : DW'(32'h11 * i);
      in_data[i*DW +: DW] = lane;
      if (v.mask[i]) begin
        w.addr = v.base + AW'(i) * stride;
        w.data = lane;
        exp_q.push_back(w);
      end
    end
    in_valid     = 1'b1;
    in_base_addr = v.base;
    in_mask      = v.mask;
    in_stride    = v.stride;
    mem_ready    = 1'b1;
    @(negedge clk);
    in_valid = v.noise;
    if (v.noise) begin
      in_data      = ~in_data;
      in_mask      = '1;
      in_base_addr = ~v.base;
    end
    k          = 1;
    acc        = 0;
    stall_left = v.stall_n;
    seen_done  = 1'b0;
    while (!seen_done && k <= 40) begin
      check("busy_active", 64'(busy), 64'd1);
      check("in_ready_busy", 64'(in_ready), 64'd0);
      if (done) begin
        check("done_cycle", 64'(k), 64'(v.exp_done));
        check("writes_left_at_done", 64'(exp_q.size()), 64'd0);
        check("we_at_done", 64'(mem_we), 64'd0);
        seen_done = 1'b1;
        in_valid  = 1'b0;
      end else if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(mem_we), 64'd0);
        end else begin
          check("wr_addr", 64'(mem_addr), 64'(exp_q[0].addr));
          check("wr_data", 64'(mem_wdata), 64'(exp_q[0].data));
        end
        if (acc == v.stall_at && stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          acc++;
        end
      end else begin
        check("we_or_done", 64'd0, 64'd1);
      end
      if (!seen_done) begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("done_after", 64'(done), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    tbl[0] = '{32'h0000_0100, 8'hFF, 32'd4,  -1, 0, 9,  1'b0, 1'b0};
    tbl[1] = '{32'h0000_0200, 8'h85, 32'd4,  -1, 0, 4,  1'b0, 1'b0};
    tbl[2] = '{32'h0000_0300, 8'h00, 32'd4,  -1, 0, 1,  1'b0, 1'b0};
    tbl[3] = '{32'h0000_0400, 8'hFF, 32'd4,   2, 3, 12, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFF_FFF8, 8'h0F, 32'd16, -1, 0, 5,  1'b0, 1'b0};
    tbl[5] = '{32'h0000_1000, 8'h5A, 32'd4,   1, 2, 7,  1'b1, 1'b1};

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_base_addr = '0;
    in_data      = '0;
    in_mask      = '0;
    in_stride    = 32'd4;
    mem_ready    = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    // Reset asserted while lane 4 is on the port.
    @(negedge clk);
    for (int i = 0; i < int'(LANES); i++) in_data[i*DW +: DW] = DW'(32'hA0 + i);
    in_valid     = 1'b1;
    in_base_addr = 32'h0000_0500;
    in_mask      = 8'hFF;
    in_stride    = 32'd4;
    mem_ready    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    found    = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_we && mem_addr == 32'h0000_0510) found = 1'b1;
      else @(negedge clk);
    end
    check("lane4_reached", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_we", 64'(mem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("postrst_in_ready", 64'(in_ready), 64'd1);
      check("postrst_mem_we", 64'(mem_we), 64'd0);
      check("postrst_done", 64'(done), 64'd0);
    end

    // Normal operation resumes after the aborted vector.
    run_vec(tbl[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
